alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the datapath's 4-op combinational ALU.
- Adds four operations: OR, XOR, and iterative left and arithmetic-right shifts.
- Registers the result together with a full flag set (Z, N, C, V).
- Sits between the register-file read stage and the writeback mux; upstream and downstream use valid/ready handshakes.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_core.sv | 52 +++++
 rtl/alu_pipe.sv | 155 +++++++++++++++
 tb/tb_alu_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared operation/state encodings for the pipelined ALU
// Revision: 1.0
// ============================================================================
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LSL = 3'b110,
    OP_ASR = 3'b111
  } alu_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == OP_LSL) || (op == OP_ASR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : combinational result, carry and overflow for the single-cycle ops
// Revision: 1.0
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             v_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  // The extra top bit of the difference is the borrow; carry is its inverse.
  assign diff_w = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    res_o = '0;
    c_o   = 1'b0;
    v_o   = 1'b0;
    case (alu_op_t'(op_i))
      OP_ADD: begin
        res_o = sum_w[MSB:0];
        c_o   = sum_w[WIDTH];
        v_o   = (a_i[MSB] == b_i[MSB]) && (sum_w[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        res_o = diff_w[MSB:0];
        c_o   = ~diff_w[WIDTH];
        v_o   = (a_i[MSB] != b_i[MSB]) && (diff_w[MSB] != a_i[MSB]);
      end
      OP_AND:  res_o = a_i & b_i;
      OP_NOT:  res_o = ~b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// alu_pipe : handshaked ALU with registered result/flags and iterative shifts
// Revision: 1.0
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             asr_q, asr_d;
  logic             cacc_q, cacc_d;
  logic             valid_q, valid_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  alu_op_t          op_w;
  logic             slot_free_w;
  logic             accept_w;
  logic [WIDTH-1:0] core_res_w;
  logic             core_c_w;
  logic             core_v_w;

  assign op_w        = alu_op_t'(ALUop);
  assign slot_free_w = !valid_q || out_ready;
  assign in_ready    = (state_q == IDLE) && slot_free_w;
  assign accept_w    = in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i  (ALUop),
    .a_i   (Ain),
    .b_i   (Bin),
    .res_o (core_res_w),
    .c_o   (core_c_w),
    .v_o   (core_v_w)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    asr_d   = asr_q;
    cacc_d  = cacc_q;
    // A held result is released whenever the consumer samples it.
    valid_d = valid_q && !out_ready;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;

    case (state_q)
      IDLE: begin
        if (accept_w) begin
          if (is_shift_op(op_w)) begin
            sreg_d  = Ain;
            cnt_d   = Bin[SHW-1:0];
            asr_d   = (op_w == OP_ASR);
            cacc_d  = 1'b0;
            state_d = SHIFT;
          end else begin
            out_d   = core_res_w;
            z_d     = (core_res_w == '0);
            n_d     = core_res_w[MSB];
            c_d     = core_c_w;
            v_d     = core_v_w;
            valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          if (asr_q) begin
            cacc_d = sreg_q[0];
            sreg_d = {sreg_q[MSB], sreg_q[MSB:1]};
          end else begin
            cacc_d = sreg_q[MSB];
            sreg_d = {sreg_q[MSB-1:0], 1'b0};
          end
          cnt_d = cnt_q - SHW'(1);
        end else if (slot_free_w) begin
          out_d   = sreg_q;
          z_d     = (sreg_q == '0);
          n_d     = sreg_q[MSB];
          c_d     = cacc_q;
          v_d     = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      sreg_q  <= '0;
      cnt_q   <= '0;
      asr_q   <= 1'b0;
      cacc_q  <= 1'b0;
      valid_q <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      asr_q   <= asr_d;
      cacc_q  <= cacc_d;
      valid_q <= valid_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign C         = c_q;
  assign V         = v_q;
  assign busy      = (state_q == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe : directed vector table plus hand sequences for shifts/handshake
// Revision: 1.0
// ============================================================================
module tb_alu_pipe;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  znvc; // {Z, N, C, V}
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUop;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_w;
  logic        Z, N, C, V;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[10];

  alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop     (ALUop),
    .Ain       (Ain),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .Z         (Z),
    .N         (N),
    .C         (C),
    .V         (V),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a shift, then count cycles (and busy cycles) until out_valid.
  task automatic run_shift(input string name, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp_out,
                           input logic exp_c, input int exp_lat);
    int n;
    int bc;
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    ALUop    = op;
    Ain      = a;
    Bin      = b;
    tick();
    in_valid = 1'b0;
    n  = 0;
    bc = 0;
    while (!out_valid && n < 40) begin
      if (busy) bc++;
      tick();
      n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_busy_cycles"}, bc, exp_lat);
    chk({name, "_out"}, {16'd0, out_w}, {16'd0, exp_out});
    chk({name, "_znvc"}, {28'd0, Z, N, C, V},
        {28'd0, (exp_out == 16'd0), exp_out[15], exp_c, 1'b0});
    chk({name, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ov;
    vecs[0] = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
    vecs[1] = '{3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b1010};
    vecs[2] = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100};
    vecs[3] = '{3'b010, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100};
    vecs[4] = '{3'b100, 16'hF0F0, 16'hFF00, 16'hFFF0, 4'b0100};
    vecs[5] = '{3'b101, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000};
    vecs[6] = '{3'b011, 16'hF0F0, 16'hFF00, 16'h00FF, 4'b0000};
    vecs[7] = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
    vecs[8] = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
    vecs[9] = '{3'b000, 16'h8000, 16'h8000, 16'h0000, 4'b1011};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ALUop     = 3'b000;
    Ain       = 16'h0000;
    Bin       = 16'h0000;
    repeat (2) tick();
    chk("reset_out", {16'd0, out_w}, 32'd0);
    chk("reset_flags", {28'd0, Z, N, C, V}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops with in_valid held high throughout.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      ALUop    = vecs[i].op;
      Ain      = vecs[i].a;
      Bin      = vecs[i].b;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_out", i), {16'd0, out_w}, {16'd0, vecs[i].res});
      chk($sformatf("vec%0d_znvc", i), {28'd0, Z, N, C, V}, {28'd0, vecs[i].znvc});
    end
    in_valid = 1'b0;
    tick();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

    run_shift("asr3", 3'b111, 16'h8001, 16'h0003, 16'hF000, 1'b0, 4);
    tick();
    run_shift("lsl2", 3'b110, 16'h4001, 16'h0002, 16'h0004, 1'b1, 3);
    tick();
    run_shift("lsl0", 3'b110, 16'h4001, 16'h0000, 16'h4001, 1'b0, 1);
    tick();

    // Held single-cycle result blocks new input, which must not be captured.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ALUop     = 3'b000;
    Ain       = 16'h0001;
    Bin       = 16'h0002;
    tick();
    Ain = 16'h0010;
    Bin = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("hold%0d_out", i), {16'd0, out_w}, 32'h0003);
      chk($sformatf("hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_release_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_release_out", {16'd0, out_w}, 32'h0003);

    // Shift result completing into a slot the consumer is not taking.
    out_ready = 1'b0;
    run_shift("lsl_bp", 3'b110, 16'h4001, 16'h0002, 16'h0004, 1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lsl_bp_hold%0d_out", i), {16'd0, out_w}, 32'h0004);
      chk($sformatf("lsl_bp_hold%0d_ready", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("lsl_bp_release_valid", {31'd0, out_valid}, 32'd0);

    // Leave a nonzero result with N=1 in the output register, then abort a shift.
    in_valid = 1'b1;
    ALUop    = 3'b001;
    Ain      = 16'h0000;
    Bin      = 16'h0001;
    tick();
    in_valid = 1'b0;
    chk("pre_abort_out", {16'd0, out_w}, 32'h0000FFFF);
    tick();
    in_valid = 1'b1;
    ALUop    = 3'b111;
    Ain      = 16'h8001;
    Bin      = 16'h000F;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_out", {16'd0, out_w}, 32'd0);
    chk("abort_flags", {28'd0, Z, N, C, V}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    ov = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) ov++;
      tick();
    end
    chk("abort_no_result", ov, 0);

    in_valid = 1'b1;
    ALUop    = 3'b000;
    Ain      = 16'h0001;
    Bin      = 16'h0002;
    tick();
    in_valid = 1'b0;
    chk("final_add_valid", {31'd0, out_valid}, 32'd1);
    chk("final_add_out", {16'd0, out_w}, 32'h0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
